// File: rtl/sbst_pkg.sv
// Shared definitions for the SBST result responder: register map, bit indices, FSM states.
// SBST_MISR_EN selects the MISR signature update instead of the additive checksum.
package sbst_pkg;

    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_STATUS   = 6'h04;
    localparam logic [5:0] OFF_SIG      = 6'h08;
    localparam logic [5:0] OFF_GOLDEN   = 6'h0C;
    localparam logic [5:0] OFF_SIG_DATA = 6'h10;
    localparam logic [5:0] OFF_COUNT    = 6'h14;

    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_CHECK = 1;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_PASS = 2;
    localparam int unsigned STAT_ERR  = 3;

    typedef enum logic [0:0] {StIdle, StWait} hs_state_e;

    function automatic logic [31:0] sbst_sig_next(input logic [31:0] sig,
                                                  input logic [31:0] wdata,
                                                  input logic [31:0] poly);
`ifdef SBST_MISR_EN
        return {sig[30:0], ^(sig & poly)} ^ wdata;
`else
        logic unused_poly;
        unused_poly = ^poly;
        return sig + wdata;
`endif
    endfunction

endpackage

// File: rtl/sbst_result_responder_signature.sv
// Signature (SIG) and word-count (COUNT) registers for the SBST responder.
// The update rule comes from sbst_sig_next(), selected by SBST_MISR_EN.
module sbst_signature
    import sbst_pkg::*;
#(
    parameter logic [31:0] POLY = 32'h04C1_1DB7,
    parameter logic [31:0] SEED = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        update,
    input  logic [31:0] wdata,
    output logic [31:0] sig,
    output logic [15:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig   <= '0;
            count <= '0;
        end else if (start) begin
            sig   <= SEED;
            count <= '0;
        end else if (update) begin
            sig   <= sbst_sig_next(sig, wdata, POLY);
            // COUNT saturates rather than wrapping
            count <= (count == 16'hFFFF) ? count : count + 16'd1;
        end
    end

endmodule

// File: rtl/sbst_result_responder.sv
// Memory-mapped SBST result responder on the req/gnt/rvalid data port.
// Build option SBST_MISR_EN switches SIG_DATA updates from checksum to MISR.
module sbst_result_responder
    import sbst_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1A11_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] POLY        = 32'h04C1_1DB7,
    parameter logic [31:0] SEED        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        test_busy_o,
    output logic        test_done_o,
    output logic        go_nogo_o
);

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    hs_state_e   state_q;
    logic [3:0]  wait_cnt_q;
    logic        hit, gnt;
    logic [5:0]  off;
    logic [31:0] golden_q, sig_val, rd_val, rdata_q, status;
    logic [15:0] count_val;
    logic        busy_q, done_q, pass_q, err_q, rvalid_q;
    logic        start, check, sig_upd, gold_wr, acc_err;

    assign hit = data_req_i && (data_addr_i[31:6] == BASE_ADDR[31:6]);
    assign off = data_addr_i[5:0];

    always_comb begin
        gnt = 1'b0;
        if (WAIT_CYCLES == 0) begin
            gnt = hit && !rst_i;
        end else begin
            gnt = (state_q == StWait) && (wait_cnt_q == 4'd0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (hit && (WAIT_CYCLES != 0)) begin
                        state_q    <= StWait;
                        wait_cnt_q <= WAIT_INIT;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy_q;
        status[STAT_DONE] = done_q;
        status[STAT_PASS] = pass_q;
        status[STAT_ERR]  = err_q;
    end

    // Access decode; all effects qualify on gnt, when the request is sampled.
    always_comb begin
        start   = 1'b0;
        check   = 1'b0;
        sig_upd = 1'b0;
        gold_wr = 1'b0;
        acc_err = 1'b0;
        rd_val  = '0;
        if (gnt) begin
            case (off)
                OFF_CTRL: begin
                    if (data_we_i) begin
                        start = data_wdata_i[CTRL_START];
                        check = data_wdata_i[CTRL_CHECK] && !data_wdata_i[CTRL_START];
                    end
                end
                OFF_STATUS: begin
                    if (data_we_i) acc_err = 1'b1;
                    else           rd_val  = status;
                end
                OFF_SIG: begin
                    if (data_we_i) acc_err = 1'b1;
                    else           rd_val  = sig_val;
                end
                OFF_GOLDEN: begin
                    if (data_we_i) gold_wr = 1'b1;
                    else           rd_val  = golden_q;
                end
                OFF_SIG_DATA: begin
                    if (data_we_i) begin
                        if (busy_q) sig_upd = 1'b1;
                        else        acc_err = 1'b1;
                    end
                end
                OFF_COUNT: begin
                    if (data_we_i) acc_err = 1'b1;
                    else           rd_val  = {16'h0000, count_val};
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            golden_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt;
            rdata_q  <= rd_val;
            if (gold_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be_i[b]) golden_q[8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
            if (start) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                pass_q <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                if (check && busy_q) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (sig_val == golden_q);
                end
                if (acc_err) err_q <= 1'b1;
            end
        end
    end

    sbst_signature #(
        .POLY (POLY),
        .SEED (SEED)
    ) u_signature (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (start),
        .update (sig_upd),
        .wdata  (data_wdata_i),
        .sig    (sig_val),
        .count  (count_val)
    );

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign test_busy_o   = busy_q;
    assign test_done_o   = done_q;
    // pass is only ever set together with done, so it is the verdict directly
    assign go_nogo_o     = pass_q;

endmodule

// File: tb/tb_sbst_result_responder.sv
// Directed bench for sbst_result_responder: zero-wait instance for register behaviour,
// three-wait instance for grant latency and reset-during-wait.
module tb_sbst_result_responder;

    localparam logic [31:0] BASE = 32'h1A11_0000;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_SIG = 6'h08;
    localparam logic [5:0] A_GOLDEN = 6'h0C, A_SDATA = 6'h10, A_COUNT = 6'h14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0, we0, gnt0, rvalid0, busy0, done0, go0;
    logic [31:0] addr0, wd0, rdata0;
    logic [3:0]  be0;
    logic        req3, we3, gnt3, rvalid3, busy3, done3, go3;
    logic [31:0] addr3, wd3, rdata3;
    logic [3:0]  be3;

    int total = 0;
    int bad = 0;

    sbst_result_responder #(
        .BASE_ADDR (BASE), .WAIT_CYCLES (0), .POLY (POLY), .SEED (32'h0)
    ) dut0 (
        .clk_i (clk), .rst_i (rst), .data_req_i (req0), .data_addr_i (addr0),
        .data_we_i (we0), .data_be_i (be0), .data_wdata_i (wd0), .data_gnt_o (gnt0),
        .data_rvalid_o (rvalid0), .data_rdata_o (rdata0), .test_busy_o (busy0),
        .test_done_o (done0), .go_nogo_o (go0)
    );

    sbst_result_responder #(
        .BASE_ADDR (BASE), .WAIT_CYCLES (3), .POLY (POLY), .SEED (32'h0)
    ) dut3 (
        .clk_i (clk), .rst_i (rst), .data_req_i (req3), .data_addr_i (addr3),
        .data_we_i (we3), .data_be_i (be3), .data_wdata_i (wd3), .data_gnt_o (gnt3),
        .data_rvalid_o (rvalid3), .data_rdata_o (rdata3), .test_busy_o (busy3),
        .test_done_o (done3), .go_nogo_o (go3)
    );

    function automatic logic [31:0] model(input logic [31:0] s, input logic [31:0] w);
`ifdef SBST_MISR_EN
        return {s[30:0], ^(s & POLY)} ^ w;
`else
        return s + w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1; returns at posedge+1 of the rvalid cycle.
    task automatic acc0(input logic we, input logic [5:0] off, input logic [31:0] wd,
                        input logic [3:0] be, output logic [31:0] rd);
        req0 = 1'b1; addr0 = BASE | {26'h0, off}; we0 = we; wd0 = wd; be0 = be;
        #1 chk("gnt0", {31'h0, gnt0}, 32'h1);
        @(posedge clk); #1;
        req0 = 1'b0; addr0 = '0; we0 = 1'b0; wd0 = '0; be0 = '0;
        chk("rvalid0", {31'h0, rvalid0}, 32'h1);
        rd = rdata0;
    endtask

    task automatic wr0(input logic [5:0] off, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] dummy;
        acc0(1'b1, off, wd, be, dummy);
    endtask

    task automatic rd0(input string tag, input logic [5:0] off, input logic [31:0] exp);
        logic [31:0] r;
        acc0(1'b0, off, 32'h0, 4'hF, r);
        chk(tag, r, exp);
    endtask

    logic [31:0] exp_sig;
    int gcyc, k;
    logic seen;

    initial begin
        rst = 1'b1;
        req0 = 0; addr0 = 0; we0 = 0; be0 = 0; wd0 = 0;
        req3 = 0; addr3 = 0; we3 = 0; be3 = 0; wd3 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs0", {gnt0, rvalid0, busy0, done0, go0, rdata0}, 37'h0);
        chk("rst_outs3", {gnt3, rvalid3, busy3, done3, go3, rdata3}, 37'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset state and unmapped access
        rd0("status_after_reset", A_STATUS, 32'h0);
        rd0("unmapped_read", 6'h3C, 32'h0);
        rd0("status_err", A_STATUS, 32'h8);
        @(posedge clk); #1;
        chk("rvalid_idle", {31'h0, rvalid0}, 32'h0);
        chk("rdata_idle", rdata0, 32'h0);

        // Back-to-back reads: second granted during first rvalid
        rd0("b2b_sig", A_SIG, 32'h0);
        rd0("b2b_count", A_COUNT, 32'h0);

        // Session A: 0x10, 0x20, golden 0x30
        wr0(A_CTRL, 32'h1, 4'hF);
        chk("start_busy", {30'h0, busy0, done0}, 32'h2);
        wr0(A_SDATA, 32'h10, 4'h0);
        wr0(A_SDATA, 32'h20, 4'h0);
        wr0(A_GOLDEN, 32'h30, 4'hF);
        wr0(A_CTRL, 32'h2, 4'hF);
        exp_sig = model(model(32'h0, 32'h10), 32'h20);
        chk("a_done_go", {30'h0, done0, go0}, {30'h0, 1'b1, exp_sig == 32'h30});
        rd0("a_sig", A_SIG, exp_sig);
        rd0("a_count", A_COUNT, 32'h2);
        rd0("a_status", A_STATUS, (exp_sig == 32'h30) ? 32'h6 : 32'h2);

        // Session B: 0x1, 0x0, golden 0x2 (MISR gives 0x3, checksum gives 0x1)
        wr0(A_CTRL, 32'h1, 4'hF);
        wr0(A_SDATA, 32'h1, 4'hF);
        wr0(A_SDATA, 32'h0, 4'hF);
        wr0(A_GOLDEN, 32'h2, 4'hF);
        wr0(A_CTRL, 32'h2, 4'hF);
        exp_sig = model(model(32'h0, 32'h1), 32'h0);
        chk("b_go", {31'h0, go0}, 32'h0);
        rd0("b_sig", A_SIG, exp_sig);
        rd0("b_status", A_STATUS, 32'h2);

        // GOLDEN byte enables
        wr0(A_GOLDEN, 32'h0, 4'hF);
        wr0(A_GOLDEN, 32'hAABB_CCDD, 4'b0010);
        rd0("golden_be", A_GOLDEN, 32'h0000_CC00);

        // Write to a read-only register
        wr0(A_STATUS, 32'hF, 4'hF);
        rd0("ro_write_err", A_STATUS, 32'hA);

        // START and CHECK together: START wins
        wr0(A_CTRL, 32'h3, 4'hF);
        chk("startcheck_outs", {30'h0, busy0, done0}, 32'h2);
        rd0("startcheck_status", A_STATUS, 32'h1);

        // SIG_DATA with no session
        wr0(A_CTRL, 32'h2, 4'hF);
        wr0(A_SDATA, 32'h55, 4'hF);
        rd0("nosess_status", A_STATUS, 32'hA);
        rd0("nosess_count", A_COUNT, 32'h0);
        rd0("nosess_sig", A_SIG, 32'h0);

        // Three-wait instance: gnt 3 cycles after req, rvalid one after
        req3 = 1'b1; addr3 = BASE | 32'h4; we3 = 1'b0; be3 = 4'hF;
        gcyc = -1; k = 0;
        while (gcyc < 0 && k < 8) begin
            #1;
            if (gnt3) gcyc = k;
            @(posedge clk); #1;
            k++;
        end
        req3 = 1'b0; addr3 = '0;
        chk("w3_gnt_cycle", gcyc, 32'd3);
        chk("w3_rvalid", {31'h0, rvalid3}, 32'h1);
        chk("w3_rdata", rdata3, 32'h0);
        @(posedge clk); #1;
        chk("w3_rvalid_once", {31'h0, rvalid3}, 32'h0);

        // Reset while in WAIT: access dropped, everything cleared
        req3 = 1'b1; addr3 = BASE | 32'h4;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        req3 = 1'b0; addr3 = '0;
        @(posedge clk); #1;
        chk("wrst_outs3", {gnt3, rvalid3, busy3, done3, go3, rdata3}, 37'h0);
        chk("wrst_outs0", {gnt0, rvalid0, busy0, done0, go0, rdata0}, 37'h0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | rvalid3 | gnt3;
        end
        chk("wrst_no_rvalid", {31'h0, seen}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbst_result_responder.md
# sbst_result_responder

Memory-mapped responder on the core data port (req/gnt/rvalid protocol) that collects self-test results from software running on the RI5CY core. Software streams result words into a signature register, loads a golden value, and triggers a compare. The block then drives a hardware go/no-go verdict alongside the existing RAM responder. It decodes its own address window; the data-port interconnect routes requests to it.

## Interface
- `BASE_ADDR`, default `32'h1A11_0000`: window base, 64 B aligned.
- `WAIT_CYCLES`, default 0: grant delay in cycles, range 0..15.
- `POLY`, default `32'h04C1_1DB7`: MISR feedback taps.
- `SEED`, default `32'h0000_0000`: signature value loaded on start.
- `clk_i` in 1: clock. One clock domain; all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `data_req_i` in 1: request.
- `data_addr_i` in 32: byte address.
- `data_we_i` in 1: write enable.
- `data_be_i` in 4: byte enables.
- `data_wdata_i` in 32: write data.
- `data_gnt_o` out 1: grant.
- `data_rvalid_o` out 1: response valid.
- `data_rdata_o` out 32: read data.
- `test_busy_o` out 1: session active.
- `test_done_o` out 1: compare performed.
- `go_nogo_o` out 1: high only when done and the signature matched.

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x00 CTRL, WO: bit0 START, bit1 CHECK.
  - 0x04 STATUS, RO: bit0 busy, bit1 done, bit2 pass, bit3 err.
  - 0x08 SIG, RO.
  - 0x0C GOLDEN, RW, byte-enable honoured.
  - 0x10 SIG_DATA, WO.
  - 0x14 COUNT, RO, 16-bit, zero-extended on read.
- Decode: hit when `data_addr_i[31:6] == BASE_ADDR[31:6]`. The responder ignores requests outside its window (no gnt).
- Access rules inside the window:
  - Unmapped offset, or write to a RO register: write ignored, read returns 0, STATUS.err set. Err is sticky until START.
  - `data_be_i` applies to GOLDEN only. CTRL and SIG_DATA use the full word regardless of be.
- START: SIG←SEED, COUNT←0, busy←1, done←0, pass←0, err←0.
- START and CHECK set in the same write: START wins, CHECK ignored.
- SIG_DATA write while busy: SIG updates, COUNT increments, saturating at 0xFFFF. SIG_DATA write while not busy: ignored, err set.
- CHECK while busy: busy←0, done←1, pass←(SIG==GOLDEN). CHECK while not busy: ignored.
- Handshake FSM:
  - IDLE: decode hit.
    - WAIT_CYCLES=0: gnt combinational in the same cycle, stay IDLE.
    - Otherwise go to WAIT, counter←WAIT_CYCLES-1.
  - WAIT: gnt asserted when counter==0, then return to IDLE; else decrement.
  - Request stability: the initiator holds req, addr, we, be and wdata stable until gnt. The responder samples them in the gnt cycle.
- Response: exactly one rvalid per gnt, in the cycle after gnt, for reads and writes alike. `data_rdata_o` is 0 whenever rvalid is low.
- Back-to-back: a new request may be granted in the same cycle as the previous rvalid. At most one outstanding.

## Timing
- All outputs 0 during and after reset. SIG, GOLDEN and COUNT reset to 0.
- Reset mid-WAIT or mid-response: the pending access is dropped and no rvalid is issued.
- Read data is registered: it returns the register value as of the gnt cycle.
- Write effects are visible to a read granted in the following cycle.
- Latency: gnt at req cycle + WAIT_CYCLES; rvalid at gnt cycle + 1.
- `test_*_o` and `go_nogo_o` are registered and change in the cycle after the granting write.

## Configuration
- `SBST_MISR_EN` defined: SIG_DATA performs a MISR update. SIG←{SIG[30:0], ^(SIG & POLY)} ^ wdata.
- Not defined: SIG←SIG + wdata, mod 2^32. POLY is unused.

## Structure
- Package `sbst_pkg` holds:
  - Register offset localparams.
  - CTRL/STATUS bit-index constants.
  - The handshake FSM state enum.
  - The `sbst_sig_next()` function, with its body selected by the macro.
- Sub-module `sbst_signature`: SIG and COUNT registers, with update, seed and saturation logic. The top level keeps decode, the FSM and the response path.

## Test plan
- Handshake, WAIT_CYCLES=0:
  - Read STATUS after reset: gnt in the same cycle, rvalid +1, rdata 0x0.
  - Read offset 0x3C: rdata 0, STATUS then reads 0x8.
- Handshake, WAIT_CYCLES=3: gnt 3 cycles after req, rvalid at 4.
- Back-to-back: two reads in consecutive cycles give two rvalids in consecutive cycles.
- Checksum mode (macro off): START, SIG_DATA 0x10 then 0x20, GOLDEN 0x30, CHECK. Expect SIG 0x30, COUNT 2, STATUS 0x6, go_nogo_o=1.
- MISR mode (SEED=0): START, SIG_DATA 0x1 then 0x0. Expect SIG 0x3. With GOLDEN 0x2, CHECK gives STATUS 0x2 and go_nogo_o=0.
- GOLDEN with be=4'b0010 and wdata 0xAABBCCDD: reads back 0x0000CC00.
- Boundaries:
  - START|CHECK in one write: busy=1, done=0.
  - SIG_DATA with no session: err set, COUNT unchanged.
  - Reset asserted in WAIT: no rvalid, and all outputs are 0 the next cycle.
